int_regfile_sb: RTL and testbench

Parametrised integer register file with two write ports, a configurable number of combinational read ports and a per-register busy scoreboard. It sits between decode and execute. Writes are committed on the rising edge and forwarded to same-cycle reads. The scoreboard tracks destinations of in-flight long-latency ops (divider, memory) so decode can stall on RAW/WAW hazards.

---
 rtl/int_regfile_sb_pkg.sv | 12 +
 rtl/int_regfile_sb_if.sv | 36 +++
 rtl/int_regfile_sb_scoreboard.sv | 53 +++++
 rtl/int_regfile_sb.sv | 78 +++++++
 tb/tb_int_regfile_sb.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/int_regfile_sb_pkg.sv
// Shared constants and types for the integer register file with busy scoreboard.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/int_regfile_sb_if.sv
// Decode-side bundle of the register file: read ports, two write-back ports and issue.
// Optional build macro affecting the slave's behaviour: REGFILE_BYPASS_EN.
interface int_regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREG);

  logic [NREAD*AW-1:0]   ra;
  logic [NREAD*XLEN-1:0] rd;
  logic [NREAD-1:0]      rd_busy;

  logic                  we0;
  logic [AW-1:0]         wa0;
  logic [XLEN-1:0]       wd0;

  logic                  we1;
  logic [AW-1:0]         wa1;
  logic [XLEN-1:0]       wd1;

  logic                  iss_v;
  logic [AW-1:0]         iss_rd;
  logic                  iss_ok;

  modport master (
    output ra, we0, wa0, wd0, we1, wa1, wd1, iss_v, iss_rd,
    input  rd, rd_busy, iss_ok
  );

  modport slave (
    input  ra, we0, wa0, wd0, we1, wa1, wd1, iss_v, iss_rd,
    output rd, rd_busy, iss_ok
  );

endinterface

// File: rtl/int_regfile_sb_scoreboard.sv
// Busy bit per register for in-flight long-latency ops, plus the iss_ok/rd_busy lookups.
// Optional build macro: REGFILE_BYPASS_EN (a same-cycle we1 also masks rd_busy).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG  = NREG_DEF,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREAD*AW-1:0] ra,
  input  logic                iss_v,
  input  logic [AW-1:0]       iss_rd,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  output logic [NREAD-1:0]    rd_busy,
  output logic                iss_ok
);

  logic [NREG-1:0] busy;

  // The set is applied after the clear so that a fresh issue supersedes the returning op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (we1 && (wa1 != '0)) begin
        busy[wa1] <= 1'b0;
      end
      if (iss_v && (iss_rd != '0)) begin
        busy[iss_rd] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (ra[i*AW +: AW] != '0) begin
        rd_busy[i] = busy[ra[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (we1 && (wa1 == ra[i*AW +: AW])) begin
          rd_busy[i] = 1'b0;
        end
`endif
      end
    end
  end

  assign iss_ok = !busy[iss_rd] || (iss_rd == '0);

endmodule

// File: rtl/int_regfile_sb.sv
// Integer register file: two write ports, NREAD combinational read ports, busy scoreboard.
// Optional build macro: REGFILE_BYPASS_EN (forward same-cycle writes, port 1 over port 0).
module int_regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREG  = NREG_DEF,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  int_regfile_sb_if.slave  bus
);

  logic [XLEN-1:0] regs  [NREG];
  logic [XLEN-1:0] rdata [NREAD];

  // Port 1 is written last so it wins a same-address collision; r0 is never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        regs[k] <= '0;
      end
    end else begin
      if (bus.we0 && (bus.wa0 != '0)) begin
        regs[bus.wa0] <= bus.wd0;
      end
      if (bus.we1 && (bus.wa1 != '0)) begin
        regs[bus.wa1] <= bus.wd1;
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0] addr;

    assign addr = bus.ra[i*AW +: AW];

    always_comb begin
      rdata[i] = regs[addr];
`ifdef REGFILE_BYPASS_EN
      if (bus.we0 && (bus.wa0 == addr)) begin
        rdata[i] = bus.wd0;
      end
      if (bus.we1 && (bus.wa1 == addr)) begin
        rdata[i] = bus.wd1;
      end
`endif
      if (addr == '0) begin
        rdata[i] = '0;
      end
    end
  end

  always_comb begin
    bus.rd = '0;
    for (int i = 0; i < NREAD; i++) begin
      bus.rd[i*XLEN +: XLEN] = rdata[i];
    end
  end

  regfile_scoreboard #(
    .NREG  (NREG),
    .NREAD (NREAD)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra      (bus.ra),
    .iss_v   (bus.iss_v),
    .iss_rd  (bus.iss_rd),
    .we1     (bus.we1),
    .wa1     (bus.wa1),
    .rd_busy (bus.rd_busy),
    .iss_ok  (bus.iss_ok)
  );

endmodule

// File: tb/tb_int_regfile_sb.sv
// Scoreboard bench for int_regfile_sb: directed cases, then random traffic vs an array model.
module tb_int_regfile_sb;
  import regfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NREAD = 2;

  typedef struct packed {
    logic [NREAD*XLEN-1:0] rd;
    logic [NREAD-1:0]      rd_busy;
    logic                  iss_ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  int_regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) bus ();

  int_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  xword_t mem_m  [NREG];
  bit     busy_m [NREG];
  exp_t   exp_q  [$];
  int     checks = 0;
  int     errors = 0;
  int     sample = 0;

  // Drive one cycle, predict the combinational outputs, then retire the cycle into the model.
  task automatic applyStimulus(input bit do_chk, input bit rstn,
                               input bit we0, input reg_addr_t wa0, input xword_t wd0,
                               input bit we1, input reg_addr_t wa1, input xword_t wd1,
                               input bit iss_v, input reg_addr_t iss_rd,
                               input reg_addr_t ra0, input reg_addr_t ra1);
    exp_t      e;
    reg_addr_t a;
    xword_t    d;
    bit        b;
    rst_n      = rstn;
    bus.we0    = we0;
    bus.wa0    = wa0;
    bus.wd0    = wd0;
    bus.we1    = we1;
    bus.wa1    = wa1;
    bus.wd1    = wd1;
    bus.iss_v  = iss_v;
    bus.iss_rd = iss_rd;
    bus.ra     = {ra1, ra0};
    if (do_chk) begin
      e = '0;
      for (int i = 0; i < NREAD; i++) begin
        a = (i == 0) ? ra0 : ra1;
        d = mem_m[a];
        b = busy_m[a];
`ifdef REGFILE_BYPASS_EN
        if (we0 && wa0 == a) d = wd0;
        if (we1 && wa1 == a) begin
          d = wd1;
          b = 1'b0;
        end
`endif
        if (a == 0) begin
          d = '0;
          b = 1'b0;
        end
        e.rd[i*XLEN +: XLEN] = d;
        e.rd_busy[i]         = b;
      end
      e.iss_ok = !busy_m[iss_rd] || (iss_rd == 0);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (!rstn) begin
      for (int k = 0; k < NREG; k++) begin
        mem_m[k]  = '0;
        busy_m[k] = 1'b0;
      end
    end else begin
      if (we0 && wa0 != 0) mem_m[wa0] = wd0;
      if (we1 && wa1 != 0) begin
        mem_m[wa1]  = wd1;
        busy_m[wa1] = 1'b0;
      end
      if (iss_v && iss_rd != 0) busy_m[iss_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic read_cycle(input reg_addr_t ra0, input reg_addr_t ra1, input reg_addr_t iss_rd);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, iss_rd, ra0, ra1);
  endtask

  task automatic checkOutput(input exp_t e);
    for (int i = 0; i < NREAD; i++) begin
      checks++;
      if (bus.rd[i*XLEN +: XLEN] !== e.rd[i*XLEN +: XLEN]) begin
        errors++;
        $display("[TB] FAIL rd[%0d] sample %0d: got %h, want %h", i, sample,
                 bus.rd[i*XLEN +: XLEN], e.rd[i*XLEN +: XLEN]);
      end
      checks++;
      if (bus.rd_busy[i] !== e.rd_busy[i]) begin
        errors++;
        $display("[TB] FAIL rd_busy[%0d] sample %0d: got %b, want %b", i, sample,
                 bus.rd_busy[i], e.rd_busy[i]);
      end
    end
    checks++;
    if (bus.iss_ok !== e.iss_ok) begin
      errors++;
      $display("[TB] FAIL iss_ok sample %0d: got %b, want %b", sample, bus.iss_ok, e.iss_ok);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (bus.iss_v && !bus.iss_ok && rst_n) begin
          errors++;
          $display("[TB] FAIL protocol sample %0d: iss_v with iss_ok=%b, want 1", sample, bus.iss_ok);
        end
        checkOutput(e);
        sample++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit        we0, we1, iss_v, rstn;
    reg_addr_t wa0, wa1, iss_rd, ra0, ra1;
    int        waited;

    for (int k = 0; k < NREG; k++) begin
      mem_m[k]  = '0;
      busy_m[k] = 1'b0;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset state");
    for (int a = 0; a < NREG; a++) begin
      read_cycle(reg_addr_t'(a), reg_addr_t'(NREG-1-a), reg_addr_t'(a));
    end

    $display("[TB] write r5 and same-cycle read");
    applyStimulus(1, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5);
    read_cycle(5, 0, 0);

    $display("[TB] writes to r0 dropped");
    applyStimulus(1, 1, 1, 0, 32'h1234, 1, 0, 32'h1234, 0, 0, 0, 0);
    read_cycle(0, 0, 0);

    $display("[TB] port collision on r7");
    applyStimulus(1, 1, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 0);
    read_cycle(7, 7, 0);

    $display("[TB] scoreboard on r9");
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    read_cycle(9, 9, 9);
    applyStimulus(1, 1, 0, 0, 0, 1, 9, 32'h99, 0, 9, 9, 0);
    read_cycle(9, 0, 9);
    applyStimulus(1, 1, 0, 0, 0, 1, 9, 32'h98, 1, 9, 9, 9);
    read_cycle(9, 9, 9);
    applyStimulus(1, 1, 1, 9, 32'h97, 0, 0, 0, 0, 9, 9, 0);
    read_cycle(9, 0, 9);

    $display("[TB] reset discards in-flight op on r3");
    applyStimulus(1, 1, 1, 3, 32'h3, 0, 0, 0, 1, 3, 3, 0);
    applyStimulus(1, 0, 1, 4, 32'h4, 1, 5, 32'h5, 1, 6, 3, 3);
    read_cycle(3, 4, 3);
    applyStimulus(1, 1, 0, 0, 0, 1, 3, 32'h33, 0, 3, 3, 5);
    read_cycle(3, 6, 3);

    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      rstn   = ($urandom_range(0, 99) != 0);
      we0    = $urandom_range(0, 1);
      we1    = $urandom_range(0, 2) == 0;
      wa0    = reg_addr_t'($urandom_range(0, 15));
      wa1    = reg_addr_t'($urandom_range(0, 15));
      iss_rd = reg_addr_t'($urandom_range(0, 15));
      ra0    = reg_addr_t'($urandom_range(0, 15));
      ra1    = ($urandom_range(0, 3) == 0) ? wa1 : reg_addr_t'($urandom_range(0, 15));
      iss_v  = ($urandom_range(0, 2) == 0) && (!busy_m[iss_rd] || iss_rd == 0);
      applyStimulus(1, rstn, we0, wa0, xword_t'($urandom), we1, wa1, xword_t'($urandom),
                    iss_v, iss_rd, ra0, ra1);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
